// File: rtl/bus_uart_if.sv
// Device-side request/response bundle between the bus hub and the UART.
// Same-cycle request qualification; the response is a one-cycle done pulse carrying rdata.
interface bus_uart_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic        ren;
    logic        active;
    logic [31:0] rdata;
    logic        done;

    modport master (
        output addr, wdata, wmask, wen, ren, active,
        input  rdata, done
    );

    modport slave (
        input  addr, wdata, wmask, wen, ren, active,
        output rdata, done
    );
endinterface

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART: bus request answered with done one cycle later, TX from a FIFO, RX into one holding register.
// A push to a full TX FIFO is dropped but still completes; a new RX byte overwrites an unread one.
module bus_uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_vld,
    input  logic [WIDTH-1:0]        push_dat,
    input  logic                    pop_vld,
    output logic [WIDTH-1:0]        head_dat,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push, do_pop;

    // Fullness is judged on the count before any same-cycle pop.
    assign do_push  = push_vld && (count_q < DEPTH_C);
    assign do_pop   = pop_vld && (count_q != '0);
    assign head_dat = mem[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

module bus_uart #(
    parameter int          TX_DEPTH  = 8,
    parameter logic [15:0] DIV_RESET = 16'd103
) (
    input  logic       clk,
    input  logic       rst,
    bus_uart_if.slave  bus,
    output logic       uart_tx,
    input  logic       uart_rx
);
    localparam int CW = $clog2(TX_DEPTH) + 1;
    localparam logic [CW-1:0] TX_DEPTH_C = CW'(TX_DEPTH);

    typedef enum logic {B_IDLE, B_RESP} bus_state_t;
    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

    bus_state_t  bus_state_q, bus_state_d;
    uart_state_t tx_state_q, tx_state_d, rx_state_q, rx_state_d;

    logic        accept, is_wr, is_rd, data_rd, stat_rd, tx_push, div_wr;
    logic [1:0]  sel;
    logic [31:0] rd_val, rdata_q;
    logic [15:0] div_q;

    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          tx_pop, tx_full, tx_empty, tx_busy;
    logic [15:0]   tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic          tx_line_q, tx_line_d;

    logic        rx_s1_q, rx_s2_q;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_wait_q, rx_wait_d, rx_store, rx_ferr_set;
    logic        rx_valid_q, rx_overrun_q, frame_err_q;
    logic [16:0] rx_half;
    logic        unused_bits;

    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:16], bus.wmask[3:2], rx_half[16]};

    // Bus request FSM
    always_comb begin
        bus_state_d = bus_state_q;
        accept      = 1'b0;
        case (bus_state_q)
            B_IDLE: if (bus.active && (bus.ren || bus.wen)) begin
                accept      = 1'b1;
                bus_state_d = B_RESP;
            end
            B_RESP:  bus_state_d = B_IDLE;
            default: bus_state_d = B_IDLE;
        endcase
    end

    assign sel     = bus.addr[3:2];
    assign is_wr   = accept && bus.wen;
    assign is_rd   = accept && bus.ren && !bus.wen;
    assign data_rd = is_rd && (sel == 2'd0);
    assign stat_rd = is_rd && (sel == 2'd1);
    assign tx_push = is_wr && (sel == 2'd0) && bus.wmask[0];
    assign div_wr  = is_wr && (sel == 2'd2);

    assign tx_full  = (fifo_count == TX_DEPTH_C);
    assign tx_empty = (fifo_count == '0);
    assign tx_busy  = (tx_state_q != U_IDLE);

    always_comb begin
        case (sel)
            2'd0:    rd_val = {23'b0, rx_valid_q, rx_byte_q};
            2'd1:    rd_val = {26'b0, frame_err_q, tx_busy, rx_overrun_q, rx_valid_q, tx_empty, tx_full};
            2'd2:    rd_val = {16'b0, div_q};
            default: rd_val = '0;
        endcase
    end

    assign bus.done  = (bus_state_q == B_RESP);
    assign bus.rdata = rdata_q;
    assign uart_tx   = tx_line_q;

    bus_uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (tx_push),
        .push_dat (bus.wdata[7:0]),
        .pop_vld  (tx_pop),
        .head_dat (fifo_head),
        .count    (fifo_count)
    );

    // TX engine; the line is registered so the start bit appears the cycle after the pop.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_line_d  = tx_line_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            U_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_div_d   = div_q;
                tx_cnt_d   = div_q;
                tx_shift_d = fifo_head;
                tx_line_d  = 1'b0;
                tx_state_d = U_START;
            end
            U_START: if (tx_cnt_q == '0) begin
                tx_cnt_d   = tx_div_q;
                tx_bit_d   = 3'd0;
                tx_line_d  = tx_shift_q[0];
                tx_state_d = U_DATA;
            end else begin
                tx_cnt_d = tx_cnt_q - 16'd1;
            end
            U_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d = tx_div_q;
                if (tx_bit_q == 3'd7) begin
                    tx_line_d  = 1'b1;
                    tx_state_d = U_STOP;
                end else begin
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_line_d  = tx_shift_q[1];
                end
            end else begin
                tx_cnt_d = tx_cnt_q - 16'd1;
            end
            U_STOP: if (tx_cnt_q == '0) begin
                // Chain straight into the next start bit when more data is queued.
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_div_d   = div_q;
                    tx_cnt_d   = div_q;
                    tx_shift_d = fifo_head;
                    tx_line_d  = 1'b0;
                    tx_state_d = U_START;
                end else begin
                    tx_state_d = U_IDLE;
                end
            end else begin
                tx_cnt_d = tx_cnt_q - 16'd1;
            end
            default: tx_state_d = U_IDLE;
        endcase
    end

    assign rx_half = ({1'b0, div_q} + 17'd1) >> 1;

    // RX engine; START waits half a bit so DATA samples land mid-bit.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_div_d    = rx_div_q;
        rx_shift_d  = rx_shift_q;
        rx_bit_d    = rx_bit_q;
        rx_wait_d   = rx_wait_q;
        rx_store    = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state_q)
            U_IDLE: if (!rx_s2_q) begin
                rx_div_d   = div_q;
                rx_cnt_d   = rx_half[15:0] - 16'd1;
                rx_state_d = U_START;
            end
            U_START: if (rx_cnt_q == '0) begin
                rx_cnt_d   = rx_div_q;
                rx_bit_d   = 3'd0;
                rx_state_d = rx_s2_q ? U_IDLE : U_DATA;
            end else begin
                rx_cnt_d = rx_cnt_q - 16'd1;
            end
            U_DATA: if (rx_cnt_q == '0) begin
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_cnt_d   = rx_div_q;
                if (rx_bit_q == 3'd7) rx_state_d = U_STOP;
                else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
                rx_cnt_d = rx_cnt_q - 16'd1;
            end
            U_STOP: if (rx_wait_q) begin
                if (rx_s2_q) begin
                    rx_wait_d  = 1'b0;
                    rx_state_d = U_IDLE;
                end
            end else if (rx_cnt_q == '0) begin
                if (rx_s2_q) begin
                    rx_store   = 1'b1;
                    rx_state_d = U_IDLE;
                end else begin
                    rx_ferr_set = 1'b1;
                    rx_wait_d   = 1'b1;
                end
            end else begin
                rx_cnt_d = rx_cnt_q - 16'd1;
            end
            default: rx_state_d = U_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_state_q  <= B_IDLE;
            rdata_q      <= '0;
            div_q        <= DIV_RESET;
            tx_state_q   <= U_IDLE;
            tx_cnt_q     <= '0;
            tx_div_q     <= '0;
            tx_shift_q   <= '0;
            tx_bit_q     <= '0;
            tx_line_q    <= 1'b1;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_state_q   <= U_IDLE;
            rx_cnt_q     <= '0;
            rx_div_q     <= '0;
            rx_shift_q   <= '0;
            rx_bit_q     <= '0;
            rx_wait_q    <= 1'b0;
            rx_byte_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            bus_state_q <= bus_state_d;
            if (accept)                  rdata_q <= is_rd ? rd_val : 32'd0;
            else if (bus_state_q == B_RESP) rdata_q <= '0;
            if (div_wr && bus.wmask[0]) div_q[7:0]  <= bus.wdata[7:0];
            if (div_wr && bus.wmask[1]) div_q[15:8] <= bus.wdata[15:8];

            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_line_q  <= tx_line_d;

            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_wait_q  <= rx_wait_d;
            if (rx_store) rx_byte_q <= rx_shift_q;
            // New events win over same-cycle read-to-clear.
            rx_valid_q   <= rx_store || (rx_valid_q && !data_rd);
            rx_overrun_q <= (rx_store && rx_valid_q && !data_rd) || (rx_overrun_q && !stat_rd);
            frame_err_q  <= rx_ferr_set || (frame_err_q && !stat_rd);
        end
    end
endmodule

// File: tb/tb_bus_uart.sv
// Directed bench for bus_uart: read and TX scoreboards, serial RX driver, reset cases.
module tb_bus_uart;
    localparam logic [31:0] A_DATA = 32'h4000_0000;
    localparam logic [31:0] A_STAT = 32'h4000_0004;
    localparam logic [31:0] A_DIV  = 32'h4000_0008;
    localparam logic [31:0] A_RSV  = 32'h4000_000C;

    logic clk = 1'b0;
    logic rst;
    logic uart_tx;
    logic uart_rx;

    bus_uart_if bus ();

    bus_uart #(.TX_DEPTH(8), .DIV_RESET(16'd103)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] rd_exp[$];
    logic [7:0]  tx_exp[$];
    bit          mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_xfer(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m, input bit wr, input bit has_exp);
        int lat;
        bit got;
        @(negedge clk);
        bus.addr = a; bus.wdata = d; bus.wmask = m;
        bus.wen = wr; bus.ren = !wr; bus.active = 1'b1;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $error("FAIL %s_timeout observed=no_done expected=done", tag);
            if (has_exp) void'(rd_exp.pop_front());
        end else begin
            chk({tag, "_lat"}, 32'(lat), 32'd1);
            if (has_exp) chk(tag, bus.rdata, rd_exp.pop_front());
            @(posedge clk); #1;
            chk({tag, "_pulse"}, {31'b0, bus.done}, 32'd0);
        end
        bus.wen = 1'b0; bus.ren = 1'b0; bus.active = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bus_xfer(tag, a, d, m, 1'b1, 1'b0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        rd_exp.push_back(exp);
        bus_xfer(tag, a, 32'd0, 4'd0, 1'b0, 1'b1);
    endtask

    // Serial frame at 4 clocks per bit (DIVISOR = 3).
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (4) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic tx_drain(input string tag);
        for (int i = 0; i < 3000 && tx_exp.size() != 0; i++) @(posedge clk);
        repeat (60) @(posedge clk);
        #1;
        chk(tag, 32'(tx_exp.size()), 32'd0);
    endtask

    // TX monitor: samples mid-bit and pops the expected byte at the stop bit.
    initial begin
        bit         skip;
        logic [7:0] b;
        skip = 1'b0;
        b    = '0;
        forever begin
            if (!skip) begin
                @(posedge clk); #1;
            end
            skip = 1'b0;
            if (mon_en && rst === 1'b1 && uart_tx === 1'b0) begin
                repeat (2) @(posedge clk);
                #1;
                chk("tx_start_mid", {31'b0, uart_tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(posedge clk);
                    #1;
                    b[i] = uart_tx;
                end
                repeat (4) @(posedge clk);
                #1;
                chk("tx_stop", {31'b0, uart_tx}, 32'd1);
                if (tx_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL tx_unexpected observed=0x%0h expected=no_frame", b);
                end else begin
                    chk("tx_byte", {24'b0, b}, {24'b0, tx_exp.pop_front()});
                    if (tx_exp.size() != 0) begin
                        repeat (2) @(posedge clk);
                        #1;
                        chk("tx_nogap", {31'b0, uart_tx}, 32'd0);
                        skip = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst = 1'b0;
        uart_rx = 1'b1;
        bus.addr = '0; bus.wdata = '0; bus.wmask = '0;
        bus.wen = 1'b0; bus.ren = 1'b0; bus.active = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        rd("rst_status", A_STAT, 32'h02);
        rd("rst_div", A_DIV, 32'd103);
        wr("div_b0", A_DIV, 32'hABCD_EE07, 4'b0001);
        wr("div_b1", A_DIV, 32'h0000_12FF, 4'b0010);
        rd("div_mask", A_DIV, 32'h0000_1207);
        wr("div_set", A_DIV, 32'hFFFF_0003, 4'b1111);
        rd("div_3", A_DIV, 32'd3);
        wr("rsv_wr", A_RSV, 32'hFFFF_FFFF, 4'b1111);
        rd("rsv_rd", A_RSV, 32'd0);
        wr("data_nomask", A_DATA, 32'h5A, 4'b1110);
        repeat (10) @(posedge clk);
        rd("nomask_status", A_STAT, 32'h02);

        // Single frame: start bit two cycles after the accept.
        tx_exp.push_back(8'h55);
        wr("tx55", A_DATA, 32'h55, 4'b0001);
        chk("tx_start_n2", {31'b0, uart_tx}, 32'd0);
        rd("tx_busy", A_STAT, 32'h12);
        tx_drain("tx55_drain");
        rd("tx55_idle", A_STAT, 32'h02);

        // Nine back-to-back pushes fill the FIFO after the first pop; a tenth is dropped.
        for (int i = 0; i < 9; i++) begin
            tx_exp.push_back(8'(8'h30 + i));
            wr("burst", A_DATA, 32'(8'h30 + i), 4'b0001);
        end
        rd("burst_full", A_STAT, 32'h11);
        wr("burst_drop", A_DATA, 32'hEE, 4'b0001);
        rd("burst_full2", A_STAT, 32'h11);
        tx_drain("burst_drain");
        rd("burst_idle", A_STAT, 32'h02);

        send_rx(8'hA3, 1'b1);
        repeat (4) @(posedge clk);
        rd("rx_stat", A_STAT, 32'h06);
        rd("rx_data", A_DATA, 32'h1A3);
        rd("rx_clr", A_STAT, 32'h02);

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (4) @(posedge clk);
        rd("ovr_data", A_DATA, 32'h122);
        rd("ovr_stat", A_STAT, 32'h0A);
        rd("ovr_clr", A_STAT, 32'h02);

        send_rx(8'h5C, 1'b0);
        repeat (6) @(posedge clk);
        rd("ferr_stat", A_STAT, 32'h22);
        rd("ferr_data", A_DATA, 32'h022);
        rd("ferr_clr", A_STAT, 32'h02);

        @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (60) @(posedge clk);
        rd("glitch_stat", A_STAT, 32'h02);

        // Reset in the middle of a frame of zeros, with one more byte queued.
        mon_en = 1'b0;
        wr("pre_rst_w0", A_DATA, 32'h00, 4'b0001);
        wr("pre_rst_w1", A_DATA, 32'h00, 4'b0001);
        repeat (10) @(posedge clk);
        #3;
        chk("pre_rst_tx", {31'b0, uart_tx}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_async_tx", {31'b0, uart_tx}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        rd("rst2_status", A_STAT, 32'h02);
        rd("rst2_div", A_DIV, 32'd103);
        repeat (50) @(posedge clk);
        #1;
        chk("rst2_idle_tx", {31'b0, uart_tx}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
